// File: rtl/mem_bus_arbiter.sv
// Two-master (A = CPU, B = loader/debug) arbiter for the 256x16 RAM, LED register and switches.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise port A has fixed priority.
module mem_bus_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  a_cmd,
  input  logic [8:0]  a_addr,
  input  logic [15:0] a_wdata,
  output logic [15:0] a_rdata,
  output logic        a_ack,
  output logic        a_wait,
  input  logic [6:0]  b_cmd,
  input  logic [8:0]  b_addr,
  input  logic [15:0] b_wdata,
  output logic [15:0] b_rdata,
  output logic        b_ack,
  output logic        b_wait,
  output logic [7:0]  ram_addr,
  output logic        ram_we,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_q,
  input  logic [7:0]  sw,
  output logic [7:0]  led,
  output logic [1:0]  grant
);

  localparam logic [6:0] M_READ  = 7'b1100000;
  localparam logic [6:0] M_WRITE = 7'b1110000;
  localparam logic [8:0] LED_ADDR = 9'h100;
  localparam logic [8:0] SW_ADDR  = 9'h140;

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACK} state_t;

  state_t      r_state;
  logic        r_ownerB;
  logic        r_write;
  logic [8:0]  r_addr;
  logic [7:0]  r_ledData;
  logic [1:0]  r_grant;
`ifdef ARB_ROUND_ROBIN_EN
  logic        r_favorB;
`endif

  logic        w_aReq;
  logic        w_bReq;
  logic        w_pickB;
  logic        w_newWrite;
  logic [8:0]  w_newAddr;
  logic [15:0] w_newWdata;
  logic [15:0] w_readData;

  assign w_aReq = (a_cmd == M_READ) || (a_cmd == M_WRITE);
  assign w_bReq = (b_cmd == M_READ) || (b_cmd == M_WRITE);

  // B wins only when A is silent, unless round-robin says it is B's turn
`ifdef ARB_ROUND_ROBIN_EN
  assign w_pickB = w_bReq && (!w_aReq || r_favorB);
`else
  assign w_pickB = w_bReq && !w_aReq;
`endif

  assign w_newWrite = w_pickB ? (b_cmd == M_WRITE) : (a_cmd == M_WRITE);
  assign w_newAddr  = w_pickB ? b_addr  : a_addr;
  assign w_newWdata = w_pickB ? b_wdata : a_wdata;

  assign a_wait = w_aReq && !a_ack;
  assign b_wait = w_bReq && !b_ack;
  assign grant  = r_grant;

  always_comb begin
    w_readData = 16'h0000;
    if (!r_addr[8])
      w_readData = ram_q;
    else if (r_addr == LED_ADDR)
      w_readData = {8'h00, led};
    else if (r_addr == SW_ADDR)
      w_readData = {8'h00, sw};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_ownerB  <= 1'b0;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_ledData <= '0;
      r_grant   <= 2'b00;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      led       <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_favorB  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_aReq || w_bReq) begin
            r_ownerB  <= w_pickB;
            r_write   <= w_newWrite;
            r_addr    <= w_newAddr;
            r_ledData <= w_newWdata[7:0];
            r_grant   <= w_pickB ? 2'b10 : 2'b01;
            ram_addr  <= w_newAddr[7:0];
            ram_wdata <= w_newWdata;
            ram_we    <= w_newWrite && !w_newAddr[8];
`ifdef ARB_ROUND_ROBIN_EN
            r_favorB  <= !w_pickB;
`endif
            r_state   <= ACCESS;
          end
        end
        ACCESS: begin
          ram_we <= 1'b0;
          if (r_write) begin
            if (r_addr == LED_ADDR)
              led <= r_ledData;
            a_ack   <= !r_ownerB;
            b_ack   <= r_ownerB;
            r_state <= ACK;
          end else begin
            r_state <= CAPTURE;
          end
        end
        CAPTURE: begin
          // ram_q now reflects the address presented during ACCESS
          if (r_ownerB)
            b_rdata <= w_readData;
          else
            a_rdata <= w_readData;
          a_ack   <= !r_ownerB;
          b_ack   <= r_ownerB;
          r_state <= ACK;
        end
        ACK: begin
          a_ack   <= 1'b0;
          b_ack   <= 1'b0;
          r_grant <= 2'b00;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: a transaction-level model tracks each access by its cycle offset
// and is compared against the DUT every cycle, plus directed literal checks of the headline cases.
module tb_mem_bus_arbiter;

   localparam logic [6:0] CMD_READ  = 7'b1100000;
   localparam logic [6:0] CMD_WRITE = 7'b1110000;
   localparam logic [6:0] CMD_NONE  = 7'b1010000;

   logic        clk;
   logic        reset_n;
   logic [6:0]  a_cmd, b_cmd;
   logic [8:0]  a_addr, b_addr;
   logic [15:0] a_wdata, b_wdata, a_rdata, b_rdata;
   logic        a_ack, a_wait, b_ack, b_wait;
   logic [7:0]  ram_addr;
   logic        ram_we;
   logic [15:0] ram_wdata, ram_q;
   logic [7:0]  sw, led;
   logic [1:0]  grant;

   int checks = 0;
   int errors = 0;
   bit cmpEn = 0;

   mem_bus_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .a_cmd(a_cmd), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(a_rdata),
      .a_ack(a_ack), .a_wait(a_wait),
      .b_cmd(b_cmd), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(b_rdata),
      .b_ack(b_ack), .b_wait(b_wait),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_q(ram_q),
      .sw(sw), .led(led), .grant(grant)
   );

   // Free-running clock, 10 time units per cycle
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM standing in for the 256x16 block: data valid one cycle after the address
   logic [15:0] ramMem [256];
   always @(posedge clk) begin
      if (ram_we) ramMem[ram_addr] <= ram_wdata;
      ram_q <= ramMem[ram_addr];
   end

   // Transaction-level reference state: one access in flight, tracked by its cycle offset
   logic [15:0] mMem [256];
   logic [7:0]  mLed;
   logic [15:0] mARdata, mBRdata, mRamWdata;
   logic [7:0]  mRamAddr;
   logic [8:0]  mAddr;
   logic [15:0] mData;
   bit          mBusy, mOwnerB, mWrite, mFavorB, rrMode;
   int          mK, mLat;

`ifdef ARB_ROUND_ROBIN_EN
   initial rrMode = 1'b1;
`else
   initial rrMode = 1'b0;
`endif

   function automatic bit isReq(input logic [6:0] c);
      return (c == CMD_READ) || (c == CMD_WRITE);
   endfunction

   function automatic logic [15:0] srcValue(input logic [8:0] adr);
      if (adr < 9'h100)  return mMem[adr[7:0]];
      if (adr == 9'h100) return {8'h00, mLed};
      if (adr == 9'h140) return {8'h00, sw};
      return 16'h0000;
   endfunction

   // Write effects land at the end of offset 1, read data at the end of offset 2;
   // the transaction occupies offsets 1..latency, then one idle cycle precedes the next
   always @(posedge clk) begin
      if (!reset_n) begin
         mBusy = 0; mK = 0; mLat = 0; mFavorB = 0;
         mLed = 8'h00; mARdata = 16'h0000; mBRdata = 16'h0000;
         mRamAddr = 8'h00; mRamWdata = 16'h0000;
      end else if (mBusy) begin
         if (mK == 1 && mWrite) begin
            if (mAddr < 9'h100) mMem[mAddr[7:0]] = mData;
            if (mAddr == 9'h100) mLed = mData[7:0];
         end
         if (mK == 2 && !mWrite) begin
            if (mOwnerB) mBRdata = srcValue(mAddr);
            else         mARdata = srcValue(mAddr);
         end
         mK++;
         if (mK > mLat) mBusy = 0;
      end else if (isReq(a_cmd) || isReq(b_cmd)) begin
         mOwnerB   = isReq(b_cmd) && (!isReq(a_cmd) || (rrMode && mFavorB));
         mFavorB   = !mOwnerB;
         mWrite    = mOwnerB ? (b_cmd == CMD_WRITE) : (a_cmd == CMD_WRITE);
         mAddr     = mOwnerB ? b_addr : a_addr;
         mData     = mOwnerB ? b_wdata : a_wdata;
         mLat      = mWrite ? 2 : 3;
         mK        = 1;
         mBusy     = 1;
         mRamAddr  = mAddr[7:0];
         mRamWdata = mData;
      end
   end

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Every cycle: compare all outputs against the reference
   always @(negedge clk) begin
      if (cmpEn) begin
         logic [1:0] eGrant;
         logic eAAck, eBAck, eWe;
         eGrant = mBusy ? (mOwnerB ? 2'b10 : 2'b01) : 2'b00;
         eAAck  = mBusy && (mK == mLat) && !mOwnerB;
         eBAck  = mBusy && (mK == mLat) && mOwnerB;
         eWe    = mBusy && (mK == 1) && mWrite && (mAddr < 9'h100);
         checkOutput("grant",     {14'h0, grant},  {14'h0, eGrant});
         checkOutput("a_ack",     {15'h0, a_ack},  {15'h0, eAAck});
         checkOutput("b_ack",     {15'h0, b_ack},  {15'h0, eBAck});
         checkOutput("a_wait",    {15'h0, a_wait}, {15'h0, isReq(a_cmd) && !eAAck});
         checkOutput("b_wait",    {15'h0, b_wait}, {15'h0, isReq(b_cmd) && !eBAck});
         checkOutput("ram_we",    {15'h0, ram_we}, {15'h0, eWe});
         checkOutput("led",       {8'h0, led},     {8'h0, mLed});
         checkOutput("a_rdata",   a_rdata,         mARdata);
         checkOutput("b_rdata",   b_rdata,         mBRdata);
         if (eWe) begin
            checkOutput("ram_addr",  {8'h0, ram_addr}, {8'h0, mRamAddr});
            checkOutput("ram_wdata", ram_wdata,        mRamWdata);
         end
      end
   end

   task automatic applyStimulus(input logic [6:0] aC, input logic [8:0] aA, input logic [15:0] aW,
                                input logic [6:0] bC, input logic [8:0] bA, input logic [15:0] bW);
      a_cmd = aC; a_addr = aA; a_wdata = aW;
      b_cmd = bC; b_addr = bA; b_wdata = bW;
   endtask

   // Issue one command from the chosen port in an IDLE cycle, wait (bounded) for its ack, then drop it
   task automatic runTxn(input bit portB, input logic [6:0] cmd, input logic [8:0] adr,
                         input logic [15:0] wd, output int lat, output int weCount);
      if (portB) applyStimulus(CMD_NONE, 9'h0, 16'h0, cmd, adr, wd);
      else       applyStimulus(cmd, adr, wd, CMD_NONE, 9'h0, 16'h0);
      lat = -1;
      weCount = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (ram_we) weCount++;
         if (portB ? b_ack : a_ack) begin
            lat = i;
            break;
         end
      end
      if (lat < 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL ackTimeout: got no ack, expected ack within 12 cycles");
      end
      @(posedge clk); #1;
      applyStimulus(CMD_NONE, 9'h0, 16'h0, CMD_NONE, 9'h0, 16'h0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat, we, got;
      logic [1:0] grants [4];
      logic [1:0] expGrants [4];

      reset_n = 1'b0;
      sw = 8'hA5;
      applyStimulus(CMD_NONE, 9'h0, 16'h0, CMD_NONE, 9'h0, 16'h0);
      @(posedge clk); #1;
      cmpEn = 1;
      @(negedge clk);
      checkOutput("rstGrant", {14'h0, grant}, 16'h0000);
      checkOutput("rstLed",   {8'h0, led},    16'h0000);
      checkOutput("rstRdata", a_rdata | b_rdata, 16'h0000);
      checkOutput("rstRamWe", {15'h0, ram_we}, 16'h0000);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;

      // RAM write then read
      runTxn(0, CMD_WRITE, 9'h005, 16'hABCD, lat, we);
      checkOutput("wrLatency", lat[15:0], 16'd2);
      checkOutput("wrWeCycles", we[15:0], 16'd1);
      runTxn(0, CMD_READ, 9'h005, 16'h0000, lat, we);
      checkOutput("rdLatency", lat[15:0], 16'd3);
      checkOutput("rdRamData", a_rdata, 16'hABCD);

      // LED and switches
      runTxn(0, CMD_WRITE, 9'h100, 16'h1234, lat, we);
      checkOutput("ledValue", {8'h0, led}, 16'h0034);
      checkOutput("ledNoRamWe", we[15:0], 16'd0);
      runTxn(0, CMD_READ, 9'h140, 16'h0000, lat, we);
      checkOutput("swRead", a_rdata, 16'h00A5);

      // Unmapped address from port B
      runTxn(1, CMD_WRITE, 9'h1FF, 16'hFFFF, lat, we);
      checkOutput("unmapNoWe", we[15:0], 16'd0);
      checkOutput("unmapLed", {8'h0, led}, 16'h0034);
      runTxn(1, CMD_READ, 9'h1FF, 16'h0000, lat, we);
      checkOutput("unmapLatency", lat[15:0], 16'd3);
      checkOutput("unmapRead", b_rdata, 16'h0000);
      checkOutput("aRdataHeld", a_rdata, 16'h00A5);

      // Contention: both ports read continuously; last grant was B
`ifdef ARB_ROUND_ROBIN_EN
      expGrants = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
      expGrants = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
      applyStimulus(CMD_READ, 9'h005, 16'h0, CMD_READ, 9'h140, 16'h0);
      got = 0;
      for (int i = 0; i < 40 && got < 4; i++) begin
         @(negedge clk);
         if (a_ack || b_ack) begin
            grants[got] = grant;
            got++;
         end
      end
      checkOutput("contAcks", got[15:0], 16'd4);
      for (int i = 0; i < got; i++)
         checkOutput($sformatf("contGrant%0d", i), {14'h0, grants[i]}, {14'h0, expGrants[i]});
      @(posedge clk); #1;
      applyStimulus(CMD_NONE, 9'h0, 16'h0, CMD_NONE, 9'h0, 16'h0);
      @(posedge clk); #1;

      // Reset asserted during CAPTURE of a read
      applyStimulus(CMD_READ, 9'h005, 16'h0, CMD_NONE, 9'h0, 16'h0);
      repeat (3) @(negedge clk);
      checkOutput("captureGrant", {14'h0, grant}, 16'h0001);
      reset_n = 1'b0;
      @(posedge clk); #1;
      applyStimulus(CMD_NONE, 9'h0, 16'h0, CMD_NONE, 9'h0, 16'h0);
      @(negedge clk);
      checkOutput("abortAck",   {15'h0, a_ack}, 16'h0000);
      checkOutput("abortGrant", {14'h0, grant}, 16'h0000);
      checkOutput("abortRdata", a_rdata, 16'h0000);
      checkOutput("abortLed",   {8'h0, led}, 16'h0000);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Illegal command code behaves as NONE
      applyStimulus(7'b0000001, 9'h005, 16'h0, CMD_NONE, 9'h0, 16'h0);
      repeat (4) begin
         @(negedge clk);
         checkOutput("illegalWait",  {15'h0, a_wait}, 16'h0000);
         checkOutput("illegalGrant", {14'h0, grant}, 16'h0000);
      end
      @(posedge clk); #1;
      applyStimulus(CMD_NONE, 9'h0, 16'h0, CMD_NONE, 9'h0, 16'h0);

      // RAM contents survive the arbiter reset
      runTxn(0, CMD_READ, 9'h005, 16'h0000, lat, we);
      checkOutput("ramRetained", a_rdata, 16'hABCD);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
